// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide engine shared by signed and
// unsigned MULT/DIV. One accumulator serves both directions: for multiply it
// holds {partial product, remaining multiplier bits}, for divide it holds
// {partial remainder, dividend/quotient bits}. Operands are reduced to
// magnitudes on start and the sign is restored in a single FIX cycle.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]         state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               is_div_r;
   logic               neg_q_r;     // quotient / product is negative
   logic               neg_rem_r;   // remainder takes the dividend's sign
   logic [WIDTH-1:0]   opnd_r;      // |a| for multiply, |b| for divide
   logic [2*WIDTH-1:0] acc_r;
   logic               busy_r;
   logic               done_r;
   logic               div0_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;

   logic               signed_op_s;
   logic               a_neg_s;
   logic               b_neg_s;
   logic [WIDTH-1:0]   a_mag_s;
   logic [WIDTH-1:0]   b_mag_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [2*WIDTH-1:0] mul_next_s;
   logic [WIDTH:0]     div_shift_s;
   logic [WIDTH:0]     div_diff_s;
   logic [2*WIDTH-1:0] div_next_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   fix_hi_s;
   logic [WIDTH-1:0]   fix_lo_s;

   // Operand magnitudes for the request currently presented on a/b/op.
   always_comb begin
      signed_op_s = ~op[0];
      a_neg_s     = signed_op_s & a[WIDTH-1];
      b_neg_s     = signed_op_s & b[WIDTH-1];
      if (a_neg_s) begin
         a_mag_s = -a;
      end else begin
         a_mag_s = a;
      end
      if (b_neg_s) begin
         b_mag_s = -b;
      end else begin
         b_mag_s = b;
      end
   end

   // One shift-add (multiply) and one restoring shift-subtract (divide) step.
   always_comb begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
      if (acc_r[0]) begin
         mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
      end else begin
         mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
      end
      mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};

      // Bring the next dividend bit into the partial remainder; a clear
      // borrow bit means the divisor fits and the quotient bit is 1.
      div_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
      div_diff_s  = div_shift_s - {1'b0, opnd_r};
      if (!div_diff_s[WIDTH]) begin
         div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
         div_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
   end

   // Sign restoration of the finished magnitude result.
   always_comb begin
      prod_s   = acc_r;
      fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
      fix_lo_s = acc_r[WIDTH-1:0];
      if (is_div_r) begin
         if (neg_q_r) begin
            fix_lo_s = -acc_r[WIDTH-1:0];
         end else begin
            fix_lo_s = acc_r[WIDTH-1:0];
         end
         if (neg_rem_r) begin
            fix_hi_s = -acc_r[2*WIDTH-1:WIDTH];
         end else begin
            fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
         end
      end else begin
         if (neg_q_r) begin
            prod_s = -acc_r;
         end else begin
            prod_s = acc_r;
         end
         fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
         fix_lo_s = prod_s[WIDTH-1:0];
      end
   end

   // Control FSM, iteration datapath and registered result/handshake outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         is_div_r  <= 1'b0;
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
         opnd_r    <= '0;
         acc_r     <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         div0_r    <= 1'b0;
         hi_r      <= '0;
         lo_r      <= '0;
      end else begin
         done_r <= 1'b0;
         div0_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start && !abort) begin
                  is_div_r  <= op[1];
                  neg_q_r   <= a_neg_s ^ b_neg_s;
                  neg_rem_r <= a_neg_s;
                  cnt_r     <= CNT_W'(WIDTH);
                  busy_r    <= 1'b1;
                  if (op[1]) begin
                     opnd_r <= b_mag_s;
                     acc_r  <= {{WIDTH{1'b0}}, a_mag_s};
                  end else begin
                     opnd_r <= a_mag_s;
                     acc_r  <= {{WIDTH{1'b0}}, b_mag_s};
                  end
                  if (op[1] && (b == {WIDTH{1'b0}})) begin
                     state_r <= ST_DONE;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  if (is_div_r) begin
                     acc_r <= div_next_s;
                  end else begin
                     acc_r <= mul_next_s;
                  end
                  cnt_r <= cnt_r - CNT_W'(1);
                  if (cnt_r == CNT_W'(1)) begin
                     state_r <= ST_FIX;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end
            end
            ST_FIX: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               if (!abort) begin
                  hi_r   <= fix_hi_s;
                  lo_r   <= fix_lo_s;
                  done_r <= 1'b1;
               end else begin
                  done_r <= 1'b0;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               if (!abort) begin
                  done_r <= 1'b1;
                  div0_r <= 1'b1;
               end else begin
                  done_r <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign div0 = div0_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32 plus a WIDTH=8 copy).
module tb_muldiv_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div0;
   logic [31:0] hi;
   logic [31:0] lo;

   logic        start8;
   logic [1:0]  op8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        busy8;
   logic        done8;
   logic        div08;
   logic [7:0]  hi8;
   logic [7:0]  lo8;

   int errors = 0;
   int checks = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .abort(abort),
      .a(a), .b(b), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clock(clock), .reset(reset), .start(start8), .op(op8), .abort(1'b0),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .div0(div08), .hi(hi8), .lo(lo8)
   );

   always #5 clock = ~clock;

   // Present a request at the falling edge; return 1ns after the start edge.
   task automatic start_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
      @(negedge clock);
      start = 1'b1; op = o; a = aa; b = bb;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   // Wait (bounded) for done; lat = edges since start edge, -1 on timeout.
   task automatic wait_done(input int base, output int lat, output int bcyc);
      bcyc = busy ? 1 : 0;
      lat  = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clock); #1;
         if (done) begin
            lat = base + k;
            break;
         end
         if (busy) bcyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; abort = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
      start8 = 1'b0; op8 = 2'b00; a8 = 8'h0; b8 = 8'h0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({busy, done, div0, hi, lo} !== 67'h0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b div0=%b hi=%h lo=%h, want all 0", busy, done, div0, hi, lo);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_mult();
      int lat, bc;
      start_op(2'b00, 32'hFFFFFFFD, 32'd7);
      wait_done(0, lat, bc);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
      checks++;
      if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
      checks++;
      if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB || div0 !== 1'b0) begin
         errors++; $display("FAIL mult_neg3x7: got hi=%h lo=%h div0=%b want FFFFFFFF FFFFFFEB 0", hi, lo, div0);
      end
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got done=%b want 0", done); end
      start_op(2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA);
      wait_done(0, lat, bc);
      checks++;
      if ({hi, lo} !== 64'h0000_0000_0000_001E) begin
         errors++; $display("FAIL mult_neg5xneg6: got hi=%h lo=%h want 00000000 0000001E", hi, lo);
      end
   endtask

   task automatic test_unsigned();
      int lat, bc;
      start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(0, lat, bc);
      checks++;
      if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
         errors++; $display("FAIL multu_max: got hi=%h lo=%h want FFFFFFFE 00000001", hi, lo);
      end
      start_op(2'b11, 32'd100, 32'd7);
      wait_done(0, lat, bc);
      checks++;
      if (lat !== 33 || lo !== 32'd14 || hi !== 32'd2) begin
         errors++; $display("FAIL divu_100_7: got lat=%0d lo=%0d hi=%0d want 33 14 2", lat, lo, hi);
      end
   endtask

   task automatic test_div();
      int lat, bc;
      start_op(2'b10, 32'hFFFFFFF9, 32'd2);
      wait_done(0, lat, bc);
      checks++;
      if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
         errors++; $display("FAIL div_neg7_2: got lo=%h hi=%h want FFFFFFFD FFFFFFFF", lo, hi);
      end
      start_op(2'b10, 32'd7, 32'hFFFFFFFE);
      wait_done(0, lat, bc);
      checks++;
      if (lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin
         errors++; $display("FAIL div_7_neg2: got lo=%h hi=%h want FFFFFFFD 00000001", lo, hi);
      end
      start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
      wait_done(0, lat, bc);
      checks++;
      if (lo !== 32'h80000000 || hi !== 32'h0 || div0 !== 1'b0) begin
         errors++; $display("FAIL div_overflow: got lo=%h hi=%h div0=%b want 80000000 0 0", lo, hi, div0);
      end
   endtask

   task automatic test_div0();
      int lat, bc;
      start_op(2'b11, 32'h00000451, 32'h00000020);
      wait_done(0, lat, bc);
      checks++;
      if (lo !== 32'h22 || hi !== 32'h11) begin
         errors++; $display("FAIL div0_setup: got lo=%h hi=%h want 22 11", lo, hi);
      end
      start_op(2'b10, 32'h12345678, 32'h0);
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b1 || div0 !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL div0_pulse: got done=%b div0=%b busy=%b want 1 1 0", done, div0, busy);
      end
      checks++;
      if (hi !== 32'h11 || lo !== 32'h22) begin
         errors++; $display("FAIL div0_hold: got hi=%h lo=%h want 11 22", hi, lo);
      end
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0 || div0 !== 1'b0) begin
         errors++; $display("FAIL div0_one_cycle: got done=%b div0=%b want 0 0", done, div0);
      end
   endtask

   task automatic test_start_ignored();
      int lat, bc;
      start_op(2'b00, 32'h12345678, 32'h00000010);
      repeat (4) begin @(posedge clock); #1; end
      start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(5, lat, bc);
      checks++;
      if (lat !== 33 || hi !== 32'h00000001 || lo !== 32'h23456780) begin
         errors++; $display("FAIL start_ignored: got lat=%0d hi=%h lo=%h want 33 00000001 23456780", lat, hi, lo);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      start_op(2'b01, 32'd3, 32'd5);
      wait_done(0, lat, bc);
      checks++;
      if (lo !== 32'd15) begin errors++; $display("FAIL b2b_first: got lo=%0d want 15", lo); end
      // Still inside the done cycle: the next start lands on the following edge.
      start_op(2'b01, 32'd6, 32'd7);
      wait_done(0, lat, bc);
      checks++;
      if (lat !== 33 || lo !== 32'd42 || hi !== 32'd0) begin
         errors++; $display("FAIL b2b_second: got lat=%0d hi=%0d lo=%0d want 33 0 42", lat, hi, lo);
      end
   endtask

   task automatic test_abort();
      int seen;
      logic [31:0] hold_hi, hold_lo;
      hold_hi = hi; hold_lo = lo;
      start_op(2'b00, 32'd7, 32'd9);
      repeat (9) begin @(posedge clock); #1; end
      abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got busy=%b want 0", busy); end
      seen = 0;
      repeat (40) begin @(posedge clock); #1; if (done || div0) seen++; end
      checks++;
      if (seen !== 0 || hi !== hold_hi || lo !== hold_lo) begin
         errors++; $display("FAIL abort_no_done: got pulses=%0d hi=%h lo=%h want 0 %h %h", seen, hi, lo, hold_hi, hold_lo);
      end
      // abort and start together in IDLE: start is dropped.
      @(negedge clock);
      abort = 1'b1; start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
      @(posedge clock); #1;
      abort = 1'b0; start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_async_reset();
      int seen;
      start_op(2'b00, 32'd11, 32'd13);
      repeat (19) begin @(posedge clock); #1; end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, done, div0, hi, lo} !== 67'h0) begin
         errors++; $display("FAIL async_reset: got busy=%b done=%b div0=%b hi=%h lo=%h want all 0", busy, done, div0, hi, lo);
      end
      @(negedge clock);
      reset = 1'b1;
      seen = 0;
      repeat (40) begin @(posedge clock); #1; if (done || busy) seen++; end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL reset_no_done: got %0d active cycles want 0", seen); end
   endtask

   task automatic test_width8();
      int lat;
      @(negedge clock);
      start8 = 1'b1; op8 = 2'b00; a8 = 8'h80; b8 = 8'h80;
      @(posedge clock); #1;
      start8 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock); #1;
         if (done8) begin lat = k; break; end
      end
      checks++;
      if (lat !== 9 || {hi8, lo8} !== 16'h4000) begin
         errors++; $display("FAIL width8_mult: got lat=%0d hi=%h lo=%h want 9 40 00", lat, hi8, lo8);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_unsigned();
      test_div();
      test_div0();
      test_start_ignored();
      test_back_to_back();
      test_abort();
      test_async_reset();
      test_width8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine for the multicycle core; it replaces the separate fixed 32-bit Mult and Div blocks.
- Inputs come from the A/B register outputs; results are written to the HI/LO registers through their muxes.
- One shared radix-2 datapath handles signed and unsigned multiply and divide, using a start/done handshake with the control FSM.
- Adds several behaviours over the separate blocks: unsigned modes, a synchronous abort, busy reporting, and a defined divide-overflow result.

Parameters:
- WIDTH, 32: operand width in bits (≥4). HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived; do not override).

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: request pulse; sampled only in IDLE.
- op, input, 2: operation. 00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU. Sampled with start.
- abort, input, 1: synchronous cancel of the operation in flight.
- a, input, WIDTH: multiplicand or dividend; sampled with start.
- b, input, WIDTH: multiplier or divisor; sampled with start.
- busy, output, 1: high while an operation is in flight.
- done, output, 1: one-cycle completion pulse.
- div0, output, 1: one-cycle pulse, coincident with done, when a divide had divisor 0.
- hi, output, WIDTH: product upper half, or remainder.
- lo, output, WIDTH: product lower half, or quotient.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, div0 = 0; hi, lo = 0; counter and internal registers = 0.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE, start=1 (edge N):
  - Latch op, |a|, |b| (magnitudes for signed ops) and the result-sign flags.
  - Counter = WIDTH; busy=1.
  - Divide with b==0 → DONE. Otherwise → RUN.
- RUN, one iteration per edge, counter decrements:
  - Multiply: shift-add over a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient and remainder are WIDTH bits each.
  - When counter reaches 0 → FIX.
- FIX: one edge. Apply the sign correction, write hi/lo, set done=1, busy=0, → IDLE.
  - Completion timing: done is high during the cycle after edge N+WIDTH+1.
- DONE (division by zero only): at edge N+1, set done=1, div0=1, busy=0, → IDLE. hi/lo keep their previous values.
- done and div0 are high for exactly one cycle; they are cleared on the next edge.
- Arithmetic rules:
  - MULT: {hi,lo} = the 2·WIDTH-bit two's-complement product.
  - MULTU: {hi,lo} = the unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV with a = most-negative and b = −1: lo = most-negative (wraps), hi = 0, no flag.
  - DIVU: unsigned quotient and remainder.
- start while busy=1: ignored. No queueing, and the operands in flight are unaffected.
- start in the same cycle as a done pulse: accepted, because the state is IDLE at that edge. Back-to-back operations are allowed.
- abort=1 while busy: → IDLE at the next edge, busy=0. No done, no div0, hi/lo unchanged.
- abort has priority over a RUN→FIX transition on the same edge.
- abort in IDLE: no effect. abort and start on the same edge: abort wins and start is dropped.
- reset low mid-operation: immediate return to reset values. No done is produced.
- hi and lo change only on the FIX edge. Between operations they hold their value.

Test Plan:
- MULT, WIDTH=32, a=0xFFFFFFFD (−3), b=7: done 33 edges after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB. busy is high for exactly 33 cycles.
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001. Then DIVU with a=100, b=7: lo=14, hi=2.
- DIV, a=−7 (0xFFFFFFF9), b=2: lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIV with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0, div0=0.
- DIV with b=0 and prior hi=0x11, lo=0x22: done and div0 both pulse one edge after start; hi/lo stay 0x11/0x22.
- Handshake:
  - A start pulse at iteration 5 of a MULT is ignored, and the result equals the first operation's result.
  - A start asserted in the done cycle begins a second operation, which completes 33 edges later.
- abort at iteration 10: busy drops next edge, no done pulse, hi/lo unchanged.
- reset pulled low at iteration 20: all outputs are 0 asynchronously.
- A WIDTH=8 instance with MULT −128 × −128 gives {hi,lo}=0x4000.
